// File: rtl/xm23_pkg.sv
// Shared types and constants for the XM23 fetch-address sequencer.
// Holds the sequencer state encoding, PC width/step and a PC alignment helper.
package xm23_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Instruction fetches are halfword aligned, so redirect targets drop bit 0.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/flush_timer.sv
// 3-bit down counter that times the bubble window after a redirect.
// load has priority over dec; the count saturates at zero.
module flush_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] cnt_d;
  logic [2:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: picks the next PC from redirects, interrupts, halts
// and stalls, and drives the pipeline hold and bubble-insert controls.
module pc_sequencer
  import xm23_pkg::*;
#(
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0]  RESET_PC     = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] true_PC,
  input  logic [7:0]      stall_req,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            branch_fail,
  input  logic [PC_W-1:0] LBPC,
  input  logic            irq_req,
  input  logic [PC_W-1:0] irq_vector,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] PC_next,
  output logic [7:0]      stall_out,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            irq_ack,
  output logic [1:0]      state_dbg
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e          state_d;
  state_e          state_q;
  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;
  logic [PC_W-1:0] pc_seq;

  assign pc_seq = true_PC + PC_STEP;

  flush_timer u_flush_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (FLUSH_LOAD),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    PC_next     = pc_seq;
    stall_out   = 8'h00;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    irq_ack     = 1'b0;

    if (rst) begin
      state_d     = ST_RUN;
      PC_next     = RESET_PC;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          stall_out = stall_req;
          if (branch_fail) begin
            PC_next  = align_pc(LBPC);
            state_d  = ST_FLUSH;
            tmr_load = 1'b1;
          end else if (irq_req) begin
            PC_next  = irq_vector;
            irq_ack  = 1'b1;
            state_d  = ST_FLUSH;
            tmr_load = 1'b1;
          end else if (halt_req) begin
            PC_next = true_PC;
            state_d = ST_HALT;
          end else if (|stall_req) begin
            // The upstream stage keeps any pending branch until the stall clears.
            PC_next = true_PC;
          end else if (branch_taken) begin
            PC_next = align_pc(branch_target);
          end
        end

        ST_FLUSH: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (branch_fail) begin
            PC_next  = align_pc(LBPC);
            tmr_load = 1'b1;
          end else if (tmr_zero) begin
            state_d = ST_RUN;
          end else begin
            tmr_dec = 1'b1;
          end
        end

        ST_HALT: begin
          stall_out = stall_req | 8'h80;
          PC_next   = true_PC;
          if (branch_fail) begin
            PC_next  = align_pc(LBPC);
            state_d  = ST_FLUSH;
            tmr_load = 1'b1;
          end else if (resume) begin
            state_d = ST_RUN;
          end
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with FLUSH_CYCLES=2, RESET_PC=0.
// Inputs change 1ns after each rising edge; outputs are checked on the falling edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] true_PC;
  logic [7:0]  stall_req;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        branch_fail;
  logic [15:0] LBPC;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        halt_req;
  logic        resume;
  logic [15:0] PC_next;
  logic [7:0]  stall_out;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        irq_ack;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.FLUSH_CYCLES(2), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .true_PC       (true_PC),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .branch_fail   (branch_fail),
    .LBPC          (LBPC),
    .irq_req       (irq_req),
    .irq_vector    (irq_vector),
    .halt_req      (halt_req),
    .resume        (resume),
    .PC_next       (PC_next),
    .stall_out     (stall_out),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .irq_ack       (irq_ack),
    .state_dbg     (state_dbg)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Checks the full output set for one cycle.
  task automatic chk_all(input string tag, input logic [15:0] pc, input logic [7:0] st,
                         input logic fl, input logic ack, input logic [1:0] sd);
    chk({tag, ".pc"}, PC_next, pc);
    chk({tag, ".stall"}, {8'h00, stall_out}, {8'h00, st});
    chk({tag, ".flush_if_id"}, {15'h0, flush_if_id}, {15'h0, fl});
    chk({tag, ".flush_id_ex"}, {15'h0, flush_id_ex}, {15'h0, fl});
    chk({tag, ".ack"}, {15'h0, irq_ack}, {15'h0, ack});
    chk({tag, ".state"}, {14'h0, state_dbg}, {14'h0, sd});
  endtask

  initial begin
    rst = 1'b1; true_PC = 16'h1234; stall_req = 8'hFF; branch_taken = 1'b0;
    branch_target = 16'h0000; branch_fail = 1'b1; LBPC = 16'h0400; irq_req = 1'b1;
    irq_vector = 16'h0FF0; halt_req = 1'b1; resume = 1'b0;

    // Reset overrides every event, two cycles.
    sample();
    chk("rst0.pc", PC_next, 16'h0000);
    chk("rst0.stall", {8'h00, stall_out}, 16'h0000);
    chk("rst0.flush", {14'h0, flush_if_id, flush_id_ex}, 16'h0003);
    chk("rst0.ack", {15'h0, irq_ack}, 16'h0000);
    next_cycle();
    sample();
    chk_all("rst1", 16'h0000, 8'h00, 1'b1, 1'b0, 2'd0);

    next_cycle();
    rst = 1'b0; stall_req = 8'h00; branch_fail = 1'b0; irq_req = 1'b0; halt_req = 1'b0;
    sample();
    chk_all("post_rst", 16'h1236, 8'h00, 1'b0, 1'b0, 2'd0);

    next_cycle();
    true_PC = 16'hFFFE;
    sample();
    chk_all("wrap", 16'h0000, 8'h00, 1'b0, 1'b0, 2'd0);

    next_cycle();
    true_PC = 16'h1000; branch_taken = 1'b1; branch_target = 16'h2001;
    sample();
    chk_all("btaken", 16'h2000, 8'h00, 1'b0, 1'b0, 2'd0);

    next_cycle();
    true_PC = 16'h3000; stall_req = 8'h05; branch_target = 16'h4000;
    sample();
    chk_all("stall_br", 16'h3000, 8'h05, 1'b0, 1'b0, 2'd0);

    // Misprediction: redirect, then exactly two bubble cycles.
    next_cycle();
    stall_req = 8'h00; branch_taken = 1'b0; branch_fail = 1'b1; LBPC = 16'h0401;
    sample();
    chk_all("bf", 16'h0400, 8'h00, 1'b0, 1'b0, 2'd0);
    next_cycle();
    branch_fail = 1'b0; true_PC = 16'h0400; stall_req = 8'hFF;
    sample();
    chk_all("bf.f1", 16'h0402, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    true_PC = 16'h0402;
    sample();
    chk_all("bf.f2", 16'h0404, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    stall_req = 8'h00; true_PC = 16'h0404;
    sample();
    chk_all("bf.run", 16'h0406, 8'h00, 1'b0, 1'b0, 2'd0);

    // Second misprediction during flush cycle 2 restarts the window.
    next_cycle();
    branch_fail = 1'b1; LBPC = 16'h0800;
    sample();
    chk("bf2.pc", PC_next, 16'h0800);
    next_cycle();
    branch_fail = 1'b0; true_PC = 16'h0800;
    sample();
    chk_all("bf2.f1", 16'h0802, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    branch_fail = 1'b1; LBPC = 16'h0500;
    sample();
    chk_all("bf2.f2", 16'h0500, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    branch_fail = 1'b0; true_PC = 16'h0500;
    sample();
    chk_all("bf2.f3", 16'h0502, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    sample();
    chk_all("bf2.f4", 16'h0502, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    sample();
    chk_all("bf2.run", 16'h0502, 8'h00, 1'b0, 1'b0, 2'd0);

    // irq and branch_fail together: branch wins, irq waits out the flush.
    next_cycle();
    branch_fail = 1'b1; LBPC = 16'h0600; irq_req = 1'b1;
    sample();
    chk_all("irqbf", 16'h0600, 8'h00, 1'b0, 1'b0, 2'd0);
    next_cycle();
    branch_fail = 1'b0; true_PC = 16'h0600;
    sample();
    chk_all("irqbf.f1", 16'h0602, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    sample();
    chk_all("irqbf.f2", 16'h0602, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    sample();
    chk_all("irq.take", 16'h0FF0, 8'h00, 1'b0, 1'b1, 2'd0);
    next_cycle();
    irq_req = 1'b0; true_PC = 16'h0FF0;
    sample();
    chk_all("irq.f1", 16'h0FF2, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    sample();
    chk_all("irq.f2", 16'h0FF2, 8'h00, 1'b1, 1'b0, 2'd1);
    next_cycle();
    sample();
    chk_all("irq.run", 16'h0FF2, 8'h00, 1'b0, 1'b0, 2'd0);

    // Halt, then resume with halt_req released.
    next_cycle();
    halt_req = 1'b1; true_PC = 16'h2000;
    sample();
    chk("halt.enter.state", {14'h0, state_dbg}, 16'h0000);
    next_cycle();
    irq_req = 1'b1;
    sample();
    chk_all("halt", 16'h2000, 8'h80, 1'b0, 1'b0, 2'd2);
    next_cycle();
    irq_req = 1'b0; halt_req = 1'b0; resume = 1'b1; stall_req = 8'h01;
    sample();
    chk_all("halt.resume", 16'h2000, 8'h81, 1'b0, 1'b0, 2'd2);
    next_cycle();
    resume = 1'b0; stall_req = 8'h00;
    sample();
    chk_all("halt.run", 16'h2002, 8'h00, 1'b0, 1'b0, 2'd0);

    // Resume with halt_req still high re-enters HALT one cycle later.
    next_cycle();
    halt_req = 1'b1;
    sample();
    next_cycle();
    resume = 1'b1;
    sample();
    chk("rehalt.h", {14'h0, state_dbg}, 16'h0002);
    next_cycle();
    resume = 1'b0;
    sample();
    chk("rehalt.run", {14'h0, state_dbg}, 16'h0000);
    next_cycle();
    sample();
    chk("rehalt.again", {14'h0, state_dbg}, 16'h0002);

    // Reset in the middle of HALT.
    next_cycle();
    rst = 1'b1;
    sample();
    chk_all("rst_halt", 16'h0000, 8'h00, 1'b1, 1'b0, 2'd2);
    next_cycle();
    rst = 1'b0; halt_req = 1'b0;
    sample();
    chk_all("rst_halt.run", 16'h2002, 8'h00, 1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning bubble cycles inserted after a redirect (legal range 1..7).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning the fetch address loaded during reset.
REQ-003 SHALL have port clk, in, 1: single clock; one clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, in, 1: reset is synchronous and active-high.
REQ-005 SHALL have port true_PC, in, 16: current program counter value.
REQ-006 SHALL have port stall_req, in, 8: per-source stall requests, one bit per source.
REQ-007 SHALL have ports branch_taken (in, 1) and branch_target (in, 16): decode-stage taken branch and its target.
REQ-008 SHALL have ports branch_fail (in, 1) and LBPC (in, 16): misprediction detected, with the recovery address.
REQ-009 SHALL have ports irq_req (in, 1, level) and irq_vector (in, 16): interrupt request and its handler address.
REQ-010 SHALL have ports halt_req (in, 1, level) and resume (in, 1, pulse).
REQ-011 SHALL have port PC_next, out, 16: next fetch address.
REQ-012 SHALL have port stall_out, out, 8: PC/pipeline hold vector.
REQ-013 SHALL have ports flush_if_id and flush_id_ex, out, 1 each: stage bubble inserts.
REQ-014 SHALL have ports irq_ack (out, 1, one-cycle pulse) and state_dbg (out, 2, current state).

Function
REQ-015 SHALL implement FSM states RUN=0, FLUSH=1, HALT=2.
REQ-016 SHALL resolve same-cycle events in priority order: rst > branch_fail > irq_req > halt_req > stall_req > branch_taken > sequential.
REQ-017 In RUN with no events, PC_next SHALL be true_PC+2, wrapping modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-018 branch_taken in RUN, with no higher event, SHALL give PC_next = branch_target with bit0 forced to 0 and SHALL cause no state change.
REQ-019 branch_fail in any state SHALL give PC_next = LBPC (bit0 cleared), enter FLUSH next cycle, and load the flush counter with FLUSH_CYCLES-1.
REQ-020 branch_fail while already in FLUSH SHALL reload the counter (restart the window).
REQ-021 In FLUSH, flush_if_id and flush_id_ex SHALL be 1, stall_out SHALL be 8'h00, and PC_next SHALL follow REQ-017.
REQ-022 FLUSH SHALL decrement the counter each cycle and return to RUN in the cycle after the counter reads 0, giving exactly FLUSH_CYCLES flush cycles.
REQ-023 irq_req in RUN, with no branch_fail, SHALL give PC_next = irq_vector, pulse irq_ack for one cycle, and enter FLUSH.
REQ-024 irq_req in FLUSH or HALT SHALL be masked and held pending (level), then taken on the first eligible RUN cycle.
REQ-025 halt_req in RUN, with no higher event, SHALL enter HALT.
REQ-026 In HALT, stall_out[7] SHALL be 1 (OR of all stall_req bits) and PC_next SHALL be true_PC.
REQ-027 resume in HALT SHALL return the FSM to RUN; if halt_req is still high, the FSM SHALL re-enter HALT in the next cycle.
REQ-028 In RUN, stall_out SHALL equal stall_req combinationally; when any bit is set, PC_next SHALL be true_PC and branch_taken SHALL be ignored (the upstream stage holds it).
REQ-029 State_dbg SHALL reflect the registered state.

Reset
REQ-030 While rst=1, outputs SHALL be: PC_next=RESET_PC, stall_out=8'h00, flush_if_id=1, flush_id_ex=1, irq_ack=0.
REQ-031 A rising edge with rst=1 SHALL set state=RUN and counter=0.
REQ-032 rst SHALL override every event, including mid-FLUSH or mid-HALT.
REQ-033 The first cycle after reset SHALL behave as RUN with PC_next = true_PC+2.

Structure
REQ-034 Package xm23_pkg SHALL hold: the state enum, PC_STEP=2, and the PC width (16).
REQ-035 The flush counter SHALL be a sub-module, flush_timer (load, decrement, zero flag, 3-bit).
REQ-036 Next-state and PC-mux logic SHALL be in pc_sequencer; outputs are combinational from state plus inputs, and state is registered.

Verification
REQ-037 rst high 2 cycles with true_PC=16'h1234 -> PC_next=16'h0000, flushes=1; after release, PC_next=16'h1236 (given true_PC=16'h1234).
REQ-038 true_PC=16'hFFFE, no events -> PC_next=16'h0000.
REQ-039 branch_fail=1 with LBPC=16'h0400 -> PC_next=16'h0400, then exactly 2 cycles of flush_if_id=flush_id_ex=1, then RUN; second branch_fail at flush cycle 2 extends the window to 2 further cycles.
REQ-040 irq_req=1 with irq_vector=16'h0FF0 and branch_fail=1 in the same cycle -> PC_next=LBPC, no irq_ack; irq taken after FLUSH with PC_next=16'h0FF0 and a single irq_ack pulse.
REQ-041 halt_req=1, then resume pulse with halt_req=0 -> stall_out[7]=1 during HALT with PC_next=true_PC; RUN resumes the cycle after resume.
REQ-042 stall_req=8'h05 with branch_taken=1 -> stall_out=8'h05, PC_next=true_PC, branch ignored.
